serial_sub: RTL and testbench

Bit-serial, LSB-first subtractor that computes D = A - B - BIN over WIDTH clock cycles using a single 1-bit full-subtractor cell and a registered borrow.
It is the subtract-side counterpart of the team's full-adder cells and is intended for area-constrained datapaths.
A start/busy/done handshake frames each operation.
D and BOUT are held stable between operations.

---
 rtl/serial_sub_pkg.sv | 20 ++
 rtl/serial_sub_fs_bit.sv | 13 +
 rtl/serial_sub.sv | 111 +++++++++++
 tb/tb_serial_sub.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: default width, FSM encoding
// and the bit-counter width helper.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Code 2'd3 is never entered; the FSM treats it like IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_sub_fs_bit.sv
// Purely combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
module fs_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial LSB-first subtractor, D = A - B - BIN over WIDTH cycles, framed by
// a start/busy/done handshake. D and BOUT hold until the next completion.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             BOUT
);

    localparam int             CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    // Only WIDTH-1 result bits are stored; the final bit goes straight into D.
    logic [WIDTH-2:0] r_res;
    logic [WIDTH-1:0] r_d;
    logic             r_borrow;
    logic             r_bout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_d;
    logic             w_bout;
    logic             w_load;
    logic             w_shift;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    fs_bit u_fs_bit (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_res_next = {w_d, r_res};

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        w_state_next = ST_IDLE;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_shift      = 1'b1;
                w_last       = (r_cnt == LAST_CNT);
                w_state_next = w_last ? ST_DONE : ST_RUN;
            end
            default: begin
                // IDLE, DONE and the unused code all accept a new start.
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            // NOTE: every register, including the datapath shifters, is cleared so an abort leaves no stale bits.
            r_state  <= ST_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_d      <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_sa     <= A;
                r_sb     <= B;
                r_borrow <= BIN;
                r_cnt    <= '0;
            end else if (w_shift) begin
                r_sa     <= r_sa >> 1;
                r_sb     <= r_sb >> 1;
                r_res    <= w_res_next[WIDTH-1:1];
                r_borrow <= w_bout;
                r_cnt    <= r_cnt + CNT_W'(1);
            end
            if (w_shift && w_last) begin
                r_d    <= w_res_next;
                r_bout <= w_bout;
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign D    = r_d;
    assign BOUT = r_bout;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed vectors on an 8-bit instance,
// then randomized operations on 8- and 16-bit instances against a wide-arithmetic model.
module tb_serial_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s8, bin8, busy8, done8, bout8;
    logic [7:0]  a8, b8, d8;
    logic        s16, bin16, busy16, done16, bout16;
    logic [15:0] a16, b16, d16;

    int n_vec = 0;
    int n_err = 0;

    serial_sub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(s8), .A(a8), .B(b8), .BIN(bin8),
        .busy(busy8), .done(done8), .D(d8), .BOUT(bout8)
    );

    serial_sub #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(s16), .A(a16), .B(b16), .BIN(bin16),
        .busy(busy16), .done(done16), .D(d16), .BOUT(bout16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        @(negedge clk);
        s8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
        @(negedge clk);
        s8 = 1'b0;
    endtask

    // Starts one negedge after the accepting edge; returns edges until done is seen.
    task automatic wait8(input bit scramble, output int edges, output int busy_cyc, output int overlap);
        edges = 0; busy_cyc = int'(busy8); overlap = 0;
        while (!done8 && edges < 64) begin
            @(negedge clk);
            edges++;
            if (busy8) busy_cyc++;
            if (busy8 && done8) overlap++;
            if (scramble && !done8) begin
                s8 = 1'($urandom_range(0, 1)); a8 = 8'($urandom); b8 = 8'($urandom);
                bin8 = 1'($urandom_range(0, 1));
            end
        end
        if (scramble) s8 = 1'b0;
    endtask

    task automatic launch16(input logic [15:0] a, input logic [15:0] b, input logic bin);
        @(negedge clk);
        s16 = 1'b1; a16 = a; b16 = b; bin16 = bin;
        @(negedge clk);
        s16 = 1'b0;
    endtask

    task automatic wait16(output int edges, output int overlap);
        edges = 0; overlap = 0;
        while (!done16 && edges < 64) begin
            @(negedge clk);
            edges++;
            if (busy16 && done16) overlap++;
            if (!done16) begin
                s16 = 1'($urandom_range(0, 1)); a16 = 16'($urandom); b16 = 16'($urandom);
                bin16 = 1'($urandom_range(0, 1));
            end
        end
        s16 = 1'b0;
    endtask

    // Directed op: launch, wait, check latency, busy length, D and BOUT.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [7:0] exp_d, input logic exp_bout);
        int edges, busy_cyc, overlap;
        launch8(a, b, bin);
        wait8(1'b0, edges, busy_cyc, overlap);
        check({tag, "_latency"}, 32'(edges), 32'd8);
        check({tag, "_busy_len"}, 32'(busy_cyc), 32'd8);
        check({tag, "_d"}, 32'(d8), 32'(exp_d));
        check({tag, "_bout"}, 32'(bout8), 32'(exp_bout));
    endtask

    initial begin
        int edges, busy_cyc, overlap, seen;
        logic [8:0]  m8;
        logic [16:0] m16;

        rst = 1'b1;
        s8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        s16 = 0; a16 = 0; b16 = 0; bin16 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_d", 32'(d8), 32'd0);
        check("rst_bout", 32'(bout8), 32'd0);

        op8("t1", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
        @(negedge clk);
        check("t1_done_pulse", 32'(done8), 32'd0);
        repeat (3) @(negedge clk);
        check("t1_d_hold_idle", 32'(d8), 32'h1E);

        op8("t2a", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        op8("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        op8("eq", 8'h77, 8'h77, 1'b0, 8'h00, 1'b0);
        op8("ripple", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);

        // Back-to-back: start held through RUN is ignored, start in DONE is taken.
        launch8(8'h10, 8'h01, 1'b0);
        s8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        wait8(1'b0, edges, busy_cyc, overlap);
        check("t3_latency", 32'(edges), 32'd8);
        check("t3_d_first", 32'(d8), 32'h0F);
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0;
        @(negedge clk);
        s8 = 1'b0;
        check("t3_no_gap_busy", 32'(busy8), 32'd1);
        check("t3_d_hold_run", 32'(d8), 32'h0F);
        wait8(1'b0, edges, busy_cyc, overlap);
        check("t3_latency2", 32'(edges), 32'd8);
        check("t3_d_second", 32'(d8), 32'h7F);
        check("t3_bout_second", 32'(bout8), 32'd0);

        // Abort mid-operation with a one-cycle reset.
        launch8(8'h12, 8'h34, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_busy", 32'(busy8), 32'd0);
        check("t4_done", 32'(done8), 32'd0);
        check("t4_d", 32'(d8), 32'd0);
        check("t4_bout", 32'(bout8), 32'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) seen++;
        end
        check("t4_no_done", 32'(seen), 32'd0);
        op8("t4_new", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic       rbin;
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom_range(0, 1));
            m8 = {1'b0, ra} - {1'b0, rb} - 9'(rbin);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            launch8(ra, rb, rbin);
            wait8(1'b1, edges, busy_cyc, overlap);
            check("r8_latency", 32'(edges), 32'd8);
            check("r8_d", 32'(d8), 32'(m8[7:0]));
            check("r8_bout", 32'(bout8), 32'(m8[8]));
            check("r8_overlap", 32'(overlap), 32'd0);
        end

        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra, rb;
            logic        rbin;
            ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom_range(0, 1));
            m16 = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            launch16(ra, rb, rbin);
            wait16(edges, overlap);
            check("r16_latency", 32'(edges), 32'd16);
            check("r16_d", 32'(d16), 32'(m16[15:0]));
            check("r16_bout", 32'(bout16), 32'(m16[16]));
            check("r16_overlap", 32'(overlap), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
